// File: rtl/matrix_scan_driver.sv
// Double-buffered row-multiplexed LED matrix driver: shows one row at a time with an
// optional blanking gap, and swaps in a new frame only at frame boundaries.
module matrix_scan_driver #(
    parameter int ROW   = 4,
    parameter int COL   = 4,
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ROW*COL-1:0]   frame_in,
    input  logic                 frame_valid,
    output logic [ROW-1:0]       row_sel,
    output logic [COL-1:0]       col_out,
    output logic                 frame_done
);

    localparam int CNT_MAX = (DWELL > BLANK) ? ((DWELL > 2) ? DWELL : 2)
                                             : ((BLANK > 2) ? BLANK : 2);
    localparam int CW = $clog2(CNT_MAX);
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROW - 1);

    typedef enum logic {
        S_BLANK,
        S_SHOW
    } state_t;

    localparam state_t S_START = (BLANK == 0) ? S_SHOW : S_BLANK;

    // The state registers describe the cycle currently on the outputs; the output
    // registers are loaded with the image of the next state.
    state_t               state, state_n;
    logic [RW-1:0]        row_idx, row_n;
    logic [CW-1:0]        phase, phase_n;
    logic [ROW*COL-1:0]   active, active_n;
    logic [ROW*COL-1:0]   pending;
    logic                 pend_flag;
    logic                 swap;
    logic [ROW-1:0]       row_sel_n;
    logic [COL-1:0]       col_n;
    logic                 done_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_START;
            row_idx <= '0;
            phase   <= '0;
        end else begin
            state   <= state_n;
            row_idx <= row_n;
            phase   <= phase_n;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row_idx;
        phase_n = phase;
        if (enable) begin
            case (state)
                S_BLANK: begin
                    if (phase == BLANK_LAST) begin
                        state_n = S_SHOW;
                        phase_n = '0;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (phase == DWELL_LAST) begin
                        phase_n = '0;
                        row_n   = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
                        state_n = (BLANK == 0) ? S_SHOW : S_BLANK;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                default: begin
                    state_n = S_START;
                    row_n   = '0;
                    phase_n = '0;
                end
            endcase
        end
    end

    // Leaving the final lit cycle of the last row is the only point a new frame may enter.
    always_comb begin
        swap = enable && (state == S_SHOW) && (phase == DWELL_LAST) && (row_idx == ROW_LAST);
        active_n = active;
        if (swap) begin
            if (frame_valid) begin
                active_n = frame_in;
            end else if (pend_flag) begin
                active_n = pending;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
        end else begin
            active <= active_n;
            if (swap) begin
                pend_flag <= 1'b0;
            end else if (frame_valid) begin
                pending   <= frame_in;
                pend_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        row_sel_n = '0;
        col_n     = '0;
        done_n    = 1'b0;
        if (enable && (state_n == S_SHOW)) begin
            for (int r = 0; r < ROW; r++) begin
                if (row_n == RW'(r)) begin
                    row_sel_n[r] = 1'b1;
                    col_n        = active_n[r*COL +: COL];
                end
            end
            done_n = (row_n == ROW_LAST) && (phase_n == DWELL_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_sel    <= '0;
            col_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            row_sel    <= row_sel_n;
            col_out    <= col_n;
            frame_done <= done_n;
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver: a frame-position model pushes the expected
// outputs for every clock into a queue, which is popped and compared after the edge.
module tb_matrix_scan_driver;

    localparam int ROW   = 4;
    localparam int COL   = 4;
    localparam int DWELL = 4;
    localparam int BLANK = 1;
    localparam int ROWP  = BLANK + DWELL;
    localparam int FRAME = ROW * ROWP;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 enable = 1'b0;
    logic [ROW*COL-1:0]   frame_in = '0;
    logic                 frame_valid = 1'b0;
    logic [ROW-1:0]       row_sel;
    logic [COL-1:0]       col_out;
    logic                 frame_done;

    typedef struct packed {
        logic [ROW-1:0] rs;
        logic [COL-1:0] co;
        logic           fd;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    // Model: m_pos is the position (0..FRAME-1) of the cycle currently displayed.
    int                 m_pos = 0;
    logic [ROW*COL-1:0] m_act = '0;
    logic [ROW*COL-1:0] m_pend = '0;
    logic               m_flag = 1'b0;

    matrix_scan_driver #(.ROW(ROW), .COL(COL), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .frame_in(frame_in),
        .frame_valid(frame_valid),
        .row_sel(row_sel),
        .col_out(col_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic model_edge(input logic r, input logic e, input logic v,
                              input logic [ROW*COL-1:0] d);
        exp_t x;
        int   row;
        x = '0;
        if (r) begin
            m_pos  = 0;
            m_act  = '0;
            m_pend = '0;
            m_flag = 1'b0;
        end else if (!e) begin
            if (v) begin
                m_pend = d;
                m_flag = 1'b1;
            end
        end else begin
            if (m_pos == FRAME - 1) begin
                if (v) begin
                    m_act  = d;
                    m_flag = 1'b0;
                end else if (m_flag) begin
                    m_act  = m_pend;
                    m_flag = 1'b0;
                end
            end else if (v) begin
                m_pend = d;
                m_flag = 1'b1;
            end
            m_pos = (m_pos + 1) % FRAME;
            row = m_pos / ROWP;
            if ((m_pos % ROWP) >= BLANK) begin
                x.rs = ROW'(1) << row;
                x.co = m_act[row*COL +: COL];
            end
            x.fd = (m_pos == FRAME - 1);
        end
        q.push_back(x);
    endtask

    task automatic check_outputs();
        exp_t x;
        x = q.pop_front();
        tests++;
        assert (row_sel === x.rs) else begin
            fails++;
            $error("FAIL row_sel cyc=%0d observed=%b expected=%b", cyc, row_sel, x.rs);
        end
        tests++;
        assert (col_out === x.co) else begin
            fails++;
            $error("FAIL col_out cyc=%0d observed=%h expected=%h", cyc, col_out, x.co);
        end
        tests++;
        assert (frame_done === x.fd) else begin
            fails++;
            $error("FAIL frame_done cyc=%0d observed=%b expected=%b", cyc, frame_done, x.fd);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic v,
                        input logic [ROW*COL-1:0] d);
        @(negedge clk);
        reset       = r;
        enable      = e;
        frame_valid = v;
        frame_in    = d;
        model_edge(r, e, v, d);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic run_to_pos(input int p);
        for (int i = 0; i < 2 * FRAME && m_pos != p; i++) step(1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        // Reset, then a single frame with only row 3 lit.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        run(2);
        step(1'b0, 1'b1, 1'b1, 16'hF000);
        run(2 * FRAME + 5);

        // Diagonal pattern over several frames.
        step(1'b0, 1'b1, 1'b1, 16'h8421);
        run(3 * FRAME);

        // Mid-frame strobes: last one wins, the first is never shown.
        step(1'b0, 1'b1, 1'b1, 16'h000F);
        run_to_pos(FRAME - 1);
        run(1);
        run_to_pos(6);
        step(1'b0, 1'b1, 1'b1, 16'h00F0);
        run_to_pos(11);
        step(1'b0, 1'b1, 1'b1, 16'h0F00);
        run(2 * FRAME);

        // Strobe on the frame_done cycle beats a held pending frame.
        run_to_pos(3);
        step(1'b0, 1'b1, 1'b1, 16'h5555);
        run_to_pos(FRAME - 1);
        step(1'b0, 1'b1, 1'b1, 16'hAAAA);
        run(2 * FRAME + 2);

        // Freeze for 6 cycles in the middle of row 1, capturing a frame while frozen.
        run_to_pos(7);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 16'h3C3C);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0);
        run(2 * FRAME + 6);

        // Reset in row 2 with a pending frame: scan restarts dark.
        run_to_pos(11);
        step(1'b0, 1'b1, 1'b1, 16'h1234);
        step(1'b1, 1'b1, 1'b0, '0);
        run(2 * FRAME + 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
